// File: rtl/pipe_ctrl.sv
// Sequencing controller for the ID/EX/MEM/WB core: shadows EX and MEM, and
// drives the ID stall, the branch flush and the operand forwarding selects.
module pipe_ctrl #(
    parameter int MUL_CYCLES = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] id_ir_i,
    input  logic        id_valid_i,
    input  logic        br_taken_i,
    input  logic        mem_ready_i,
    output logic        stall_o,
    output logic        flush_o,
    output logic [1:0]  fwd_ex_o,
    output logic [1:0]  fwd_mem_o,
    output logic        ex_valid_o,
    output logic        mem_valid_o
);

    localparam logic [3:0] OP_LW    = 4'd0;
    localparam logic [3:0] OP_SW    = 4'd1;
    localparam logic [3:0] OP_LI    = 4'd2;
    localparam logic [3:0] OP_ADDU  = 4'd3;
    localparam logic [3:0] OP_ADDIU = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_MUL   = 4'd6;
    localparam logic [3:0] OP_BGE   = 4'd7;
    localparam logic [3:0] OP_J     = 4'd8;
    localparam logic [3:0] OP_MULI  = 4'd9;

    // MULW is entered on the first stall cycle, so the counter covers the rest.
    localparam logic [3:0] CNT_INIT = (MUL_CYCLES > 1) ? 4'(MUL_CYCLES - 2) : 4'd0;

    typedef enum logic {
        RUN,
        MULW
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] exIr_q, exIr_d;
    logic        exValid_q, exValid_d;
    logic [31:0] memIr_q, memIr_d;
    logic        memValid_q, memValid_d;

    logic [3:0]      idOp, exOp, memOp;
    logic [4:0]      exRd, memRd;
    logic [1:0][4:0] idSrc;
    logic [1:0]      idSrcValid;
    logic [1:0]      exMatch, memMatch;
    logic [1:0]      fwdEx, fwdMem;
    logic            exWriter, memWriter;
    logic            freeze, flushCond, mulEntry, loadUse;
    logic            unused_ir;

    function automatic logic isWriter(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_LI) || (op == OP_ADDU) || (op == OP_ADDIU) ||
               (op == OP_SLL) || (op == OP_MUL) || (op == OP_MULI);
    endfunction

    assign idOp      = id_ir_i[31:28];
    assign exOp      = exIr_q[31:28];
    assign memOp     = memIr_q[31:28];
    assign exRd      = exIr_q[27:23];
    assign memRd     = memIr_q[27:23];
    assign exWriter  = exValid_q && isWriter(exOp);
    assign memWriter = memValid_q && isWriter(memOp);
    assign unused_ir = ^{id_ir_i[12:0], exIr_q[22:0], memIr_q[22:0]};

    always_comb begin
        idSrcValid = 2'b00;
        idSrc[0]   = id_ir_i[22:18];
        idSrc[1]   = id_ir_i[17:13];
        case (idOp)
            OP_LW, OP_ADDIU, OP_SLL, OP_MULI: idSrcValid = 2'b01;
            OP_SW: begin
                idSrcValid = 2'b11;
                idSrc[1]   = id_ir_i[27:23];
            end
            OP_ADDU, OP_MUL: idSrcValid = 2'b11;
            OP_BGE: begin
                idSrcValid = 2'b11;
                idSrc[0]   = id_ir_i[27:23];
                idSrc[1]   = id_ir_i[22:18];
            end
            default: idSrcValid = 2'b00;
        endcase
    end

    // A load result is not available in EX, so it can only be taken from MEM.
    always_comb begin
        exMatch  = 2'b00;
        memMatch = 2'b00;
        fwdEx    = 2'b00;
        fwdMem   = 2'b00;
        for (int k = 0; k < 2; k++) begin
            exMatch[k]  = id_valid_i && idSrcValid[k] && exWriter && (idSrc[k] == exRd);
            memMatch[k] = id_valid_i && idSrcValid[k] && memWriter && (idSrc[k] == memRd);
            fwdEx[k]    = exMatch[k] && (exOp != OP_LW);
            fwdMem[k]   = memMatch[k] && !fwdEx[k];
        end
    end

    assign freeze    = memValid_q && ((memOp == OP_LW) || (memOp == OP_SW)) && !mem_ready_i;
    assign flushCond = (state_q == RUN) && exValid_q && ((exOp == OP_BGE) || (exOp == OP_J)) &&
                       br_taken_i;
    assign mulEntry  = (state_q == RUN) && exValid_q && ((exOp == OP_MUL) || (exOp == OP_MULI)) &&
                       (MUL_CYCLES > 1);
    assign loadUse   = (state_q == RUN) && exValid_q && (exOp == OP_LW) && (|exMatch);

    always_comb begin
        stall_o    = 1'b0;
        flush_o    = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        exIr_d     = id_ir_i;
        exValid_d  = id_valid_i;
        memIr_d    = exIr_q;
        memValid_d = exValid_q;
        if (freeze) begin
            stall_o    = 1'b1;
            exIr_d     = exIr_q;
            exValid_d  = exValid_q;
            memIr_d    = memIr_q;
            memValid_d = memValid_q;
        end else if (state_q == MULW) begin
            if (cnt_q != 4'd0) begin
                stall_o    = 1'b1;
                cnt_d      = cnt_q - 4'd1;
                exIr_d     = exIr_q;
                exValid_d  = exValid_q;
                memIr_d    = '0;
                memValid_d = 1'b0;
            end else begin
                state_d = RUN;
            end
        end else if (flushCond) begin
            flush_o   = 1'b1;
            exIr_d    = '0;
            exValid_d = 1'b0;
        end else if (mulEntry) begin
            stall_o    = 1'b1;
            exIr_d     = exIr_q;
            exValid_d  = exValid_q;
            memIr_d    = '0;
            memValid_d = 1'b0;
            cnt_d      = CNT_INIT;
            state_d    = MULW;
        end else if (loadUse) begin
            stall_o   = 1'b1;
            exIr_d    = '0;
            exValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            cnt_q      <= 4'd0;
            exIr_q     <= '0;
            exValid_q  <= 1'b0;
            memIr_q    <= '0;
            memValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            exIr_q     <= exIr_d;
            exValid_q  <= exValid_d;
            memIr_q    <= memIr_d;
            memValid_q <= memValid_d;
        end
    end

    assign fwd_ex_o    = fwdEx;
    assign fwd_mem_o   = fwdMem;
    assign ex_valid_o  = exValid_q;
    assign mem_valid_o = memValid_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: hand-derived per-cycle expectations are queued
// with each stimulus and compared against the outputs on the falling edge.
module tb_pipe_ctrl;

    localparam logic [3:0] LW = 4'd0, SW = 4'd1, LI = 4'd2, ADDU = 4'd3, ADDIU = 4'd4;
    localparam logic [3:0] SLL = 4'd5, MUL = 4'd6, BGE = 4'd7, J = 4'd8, MULI = 4'd9;

    typedef struct {
        int         id;
        logic       sel;
        logic [7:0] bits;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] idIr;
    logic        idValid;
    logic        brTaken;
    logic        memReady;

    logic       stallA, flushA, exValidA, memValidA;
    logic [1:0] fwdExA, fwdMemA;
    logic       stallB, flushB, exValidB, memValidB;
    logic [1:0] fwdExB, fwdMemB;

    exp_t expQ[$];
    int   checkCount = 0;
    int   errorCount = 0;

    pipe_ctrl #(.MUL_CYCLES(3)) dutA (
        .clk_i(clk), .rst_i(rst), .id_ir_i(idIr), .id_valid_i(idValid),
        .br_taken_i(brTaken), .mem_ready_i(memReady),
        .stall_o(stallA), .flush_o(flushA), .fwd_ex_o(fwdExA), .fwd_mem_o(fwdMemA),
        .ex_valid_o(exValidA), .mem_valid_o(memValidA)
    );

    pipe_ctrl #(.MUL_CYCLES(1)) dutB (
        .clk_i(clk), .rst_i(rst), .id_ir_i(idIr), .id_valid_i(idValid),
        .br_taken_i(brTaken), .mem_ready_i(memReady),
        .stall_o(stallB), .flush_o(flushB), .fwd_ex_o(fwdExB), .fwd_mem_o(fwdMemB),
        .ex_valid_o(exValidB), .mem_valid_o(memValidB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
        return {op, rd, rs, rt, 13'd0};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checkCount++;
        if (obs !== expv) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Expected bits are {stall, flush, fwd_ex[1:0], fwd_mem[1:0], ex_valid, mem_valid}.
    task automatic applyStimulus(input int id, input logic r, input logic [31:0] ir,
                                 input logic v, input logic br, input logic mr,
                                 input logic sel, input logic [7:0] bits);
        exp_t e;
        @(posedge clk);
        #1;
        rst      = r;
        idIr     = ir;
        idValid  = v;
        brTaken  = br;
        memReady = mr;
        e.id   = id;
        e.sel  = sel;
        e.bits = bits;
        expQ.push_back(e);
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t       e;
            logic [7:0] obs;
            e   = expQ.pop_front();
            obs = e.sel ? {stallB, flushB, fwdExB, fwdMemB, exValidB, memValidB}
                        : {stallA, flushA, fwdExA, fwdMemA, exValidA, memValidA};
            checkOutput($sformatf("c%0d.stall", e.id), 32'(obs[7]), 32'(e.bits[7]));
            checkOutput($sformatf("c%0d.flush", e.id), 32'(obs[6]), 32'(e.bits[6]));
            checkOutput($sformatf("c%0d.fwdEx", e.id), 32'(obs[5:4]), 32'(e.bits[5:4]));
            checkOutput($sformatf("c%0d.fwdMem", e.id), 32'(obs[3:2]), 32'(e.bits[3:2]));
            checkOutput($sformatf("c%0d.exValid", e.id), 32'(obs[1]), 32'(e.bits[1]));
            checkOutput($sformatf("c%0d.memValid", e.id), 32'(obs[0]), 32'(e.bits[0]));
        end
    end

    initial begin
        rst = 1'b1; idIr = '0; idValid = 1'b0; brTaken = 1'b0; memReady = 1'b1;
        repeat (2) @(posedge clk);
        // id  rst  ir                     v   br  mr  sel  stall/flush/fwdEx/fwdMem/exV/memV
        applyStimulus( 1, 0, mk(ADDU, 3, 1, 2),   1, 0, 1, 0, 8'b0_0_00_00_0_0);
        applyStimulus( 2, 0, mk(ADDU, 4, 3, 3),   1, 0, 1, 0, 8'b0_0_11_00_1_0);
        applyStimulus( 3, 0, mk(ADDU, 5, 3, 0),   1, 0, 1, 0, 8'b0_0_00_01_1_1);
        applyStimulus( 4, 0, mk(LI, 9, 0, 0),     1, 0, 1, 0, 8'b0_0_00_00_1_1);
        applyStimulus( 5, 0, mk(LW, 5, 7, 0),     1, 0, 1, 0, 8'b0_0_00_00_1_1);
        applyStimulus( 6, 0, mk(ADDIU, 6, 5, 0),  1, 0, 1, 0, 8'b1_0_00_00_1_1);
        applyStimulus( 7, 0, mk(ADDIU, 6, 5, 0),  1, 0, 1, 0, 8'b0_0_00_01_0_1);
        applyStimulus( 8, 0, mk(MUL, 10, 1, 2),   1, 0, 1, 0, 8'b0_0_00_00_1_0);
        applyStimulus( 9, 0, mk(ADDU, 11, 10, 10), 1, 0, 1, 0, 8'b1_0_11_00_1_1);
        applyStimulus(10, 0, mk(ADDU, 11, 10, 10), 1, 0, 1, 0, 8'b1_0_11_00_1_0);
        applyStimulus(11, 0, mk(ADDU, 11, 10, 10), 1, 0, 1, 0, 8'b0_0_11_00_1_0);
        applyStimulus(12, 0, 32'd0,               0, 0, 1, 0, 8'b0_0_00_00_1_1);
        applyStimulus(13, 0, mk(LW, 12, 1, 0),    1, 0, 1, 0, 8'b0_0_00_00_0_1);
        applyStimulus(14, 0, mk(BGE, 2, 3, 0),    1, 0, 1, 0, 8'b0_0_00_00_1_0);
        applyStimulus(15, 0, mk(ADDIU, 13, 12, 0), 1, 1, 1, 0, 8'b0_1_00_01_1_1);
        applyStimulus(16, 0, mk(ADDIU, 13, 12, 0), 1, 0, 1, 0, 8'b0_0_00_00_0_1);
        applyStimulus(17, 0, mk(BGE, 2, 3, 0),    1, 0, 1, 0, 8'b0_0_00_00_1_0);
        applyStimulus(18, 0, mk(LI, 14, 0, 0),    1, 0, 1, 0, 8'b0_0_00_00_1_1);
        applyStimulus(19, 0, 32'd0,               0, 1, 1, 0, 8'b0_0_00_00_1_1);
        applyStimulus(20, 0, mk(SW, 4, 1, 0),     1, 0, 1, 0, 8'b0_0_00_00_0_1);
        applyStimulus(21, 0, mk(MUL, 15, 1, 2),   1, 0, 1, 0, 8'b0_0_00_00_1_0);
        for (int i = 0; i < 3; i++)
            applyStimulus(22 + i, 0, mk(ADDU, 16, 15, 0), 1, 0, 0, 0, 8'b1_0_01_00_1_1);
        applyStimulus(25, 0, mk(ADDU, 16, 15, 0), 1, 0, 1, 0, 8'b1_0_01_00_1_1);
        applyStimulus(26, 0, mk(ADDU, 16, 15, 0), 1, 0, 1, 0, 8'b1_0_01_00_1_0);
        applyStimulus(27, 0, mk(ADDU, 16, 15, 0), 1, 0, 1, 0, 8'b0_0_01_00_1_0);
        applyStimulus(28, 0, mk(SW, 4, 1, 0),     1, 0, 1, 0, 8'b0_0_00_00_1_1);
        applyStimulus(29, 0, mk(J, 0, 0, 0),      1, 0, 1, 0, 8'b0_0_00_00_1_1);
        applyStimulus(30, 0, mk(LI, 18, 0, 0),    1, 1, 0, 0, 8'b1_0_00_00_1_1);
        applyStimulus(31, 0, mk(LI, 18, 0, 0),    1, 1, 1, 0, 8'b0_1_00_00_1_1);
        applyStimulus(32, 0, 32'd0,               0, 0, 1, 0, 8'b0_0_00_00_0_1);
        applyStimulus(33, 0, mk(MULI, 19, 1, 0),  1, 0, 1, 0, 8'b0_0_00_00_0_0);
        applyStimulus(34, 0, 32'd0,               0, 0, 1, 0, 8'b1_0_00_00_1_0);
        applyStimulus(35, 1, 32'd0,               0, 0, 1, 0, 8'b1_0_00_00_1_0);
        applyStimulus(36, 0, 32'd0,               0, 0, 1, 0, 8'b0_0_00_00_0_0);
        applyStimulus(37, 0, mk(MUL, 21, 1, 2),   1, 0, 1, 1, 8'b0_0_00_00_0_0);
        applyStimulus(38, 0, mk(ADDU, 22, 21, 1), 1, 0, 1, 1, 8'b0_0_01_00_1_0);
        applyStimulus(39, 0, mk(ADDU, 21, 21, 22), 1, 0, 1, 1, 8'b0_0_10_01_1_1);
        applyStimulus(40, 0, mk(ADDIU, 21, 21, 0), 1, 0, 1, 1, 8'b0_0_01_00_1_1);
        applyStimulus(41, 0, mk(SLL, 26, 21, 0),  1, 0, 1, 1, 8'b0_0_01_00_1_1);
        @(posedge clk);
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 4-stage ID/EX/MEM/WB integer core. It shadows the instructions in EX and MEM, and generates the ID stall, the branch/jump flush and the per-operand forwarding selects. It holds EX for the multi-cycle multiplier and freezes the pipe while memory is not ready. The datapath registers follow `stall_o` and `flush_o`; operand muxes follow `fwd_ex_o` and `fwd_mem_o`.

## Interface
- `MUL_CYCLES`, default 3: EX occupancy of MUL/MULI in cycles; legal range 1..16.
- `clk_i` input 1: clock; all state updates on rising edge.
- `rst_i` input 1: synchronous reset, active-high.
- `id_ir_i` input 32: instruction in decode.
- `id_valid_i` input 1: `id_ir_i` holds a real instruction.
- `br_taken_i` input 1: EX branch resolved taken (BGE) or J in EX.
- `mem_ready_i` input 1: memory completes the LW/SW in MEM this cycle.
- `stall_o` output 1: hold PC and ID register this cycle.
- `flush_o` output 1: squash ID and fetch; redirect PC.
- `fwd_ex_o` output 2: bit0/bit1 means ID source s1/s2 takes the EX result.
- `fwd_mem_o` output 2: bit0/bit1 means ID source s1/s2 takes the MEM result.
- `ex_valid_o` output 1: EX shadow valid.
- `mem_valid_o` output 1: MEM shadow valid.

## Operation
- Opcode is [31:28]: LW=0, SW=1, LI=2, ADDU=3, ADDIU=4, SLL=5, MUL=6, BGE=7, J=8, MULI=9. Fields are rd [27:23], rs [22:18], rt [17:13].
- Writers are LW, LI, ADDU, ADDIU, SLL, MUL and MULI; each writes rd.
- ID sources by opcode:
  - LW, ADDIU, SLL, MULI: s1=rs.
  - SW: s1=rs, s2=rd.
  - ADDU, MUL: s1=rs, s2=rt.
  - BGE: s1=rd, s2=rs.
  - LI, J, other opcodes: no sources.
- Register 0 gets no special treatment.
- A source match requires `id_valid_i`, the source to exist, a valid writer in the stage, and an equal 5-bit register number.
- Shadows are EX {ir, valid} and MEM {ir, valid}. A bubble is valid=0. Opcode 0 is LW, so validity comes only from the valid bit.
- Forwarding (combinational, evaluated every cycle):
  - `fwd_ex_o[k]` is set on a match with EX, when EX is not LW.
  - `fwd_mem_o[k]` is set on a match with MEM, when `fwd_ex_o[k]`=0.
- FSM has two states, RUN and MULW, plus a 4-bit counter `cnt`.
- Priority each cycle (highest first):
  1. `rst_i`
  2. freeze
  3. flush
  4. multiply
  5. load-use
  6. advance
- Freeze: MEM holds a valid LW/SW and `mem_ready_i`=0.
  - All shadows, state and `cnt` hold.
  - `stall_o`=1, `flush_o`=0.
- Flush: RUN, EX holds a valid BGE or J, and `br_taken_i`=1.
  - `flush_o`=1, `stall_o`=0.
  - MEM gets EX; EX gets a bubble.
  - `br_taken_i` is ignored in all other cases.
- Multiply entry: RUN, EX holds a valid MUL/MULI, and `MUL_CYCLES`>1.
  - `stall_o`=1; MEM gets a bubble; EX holds.
  - `cnt` gets `MUL_CYCLES`-2; state goes to MULW.
- MULW:
  - `cnt`≠0: `stall_o`=1, `cnt` decrements, MEM gets a bubble, EX holds.
  - `cnt`=0: `stall_o`=0, advance, state goes to RUN.
- Load-use: RUN, EX holds a valid LW, and its rd matches an ID source.
  - `stall_o`=1; MEM gets EX; EX gets a bubble.
- Advance: MEM gets EX; EX gets {`id_ir_i`, `id_valid_i`}.

## Timing
- Reset (one edge): shadows get ir=0 and valid=0; state goes to RUN; `cnt` gets 0.
- After reset, all outputs are 0 and stay combinationally 0 until `id_valid_i` rises.
- All outputs are combinational from the shadows, state, `cnt` and current inputs; there is no output register.
- Flush takes effect in the same cycle `br_taken_i` is seen.
- During freeze the datapath holds EX, so `br_taken_i` stays asserted; the flush then fires in the first unfrozen cycle.
- A MUL stalls ID for exactly `MUL_CYCLES`-1 cycles; with `MUL_CYCLES`=1 it does not stall.
- A load-use hazard stalls for exactly 1 cycle. After that, the LW is in MEM and `fwd_mem_o` selects it.
- Freeze in MULW pauses `cnt`, so total stall equals multiply stall plus freeze cycles.
- Reset mid-multiply or mid-freeze returns to RUN with empty shadows on the next edge.

## Test plan
- ADDU r3,r1,r2 then ADDU r4,r3,r3 (back-to-back) -> `fwd_ex_o`=2'b11, `stall_o`=0. One cycle later, with an ADDU r5,r3,r0 in ID -> `fwd_mem_o`=2'b01.
- LW r5 then ADDIU r6,r5 -> `stall_o`=1 for 1 cycle, EX bubble. Next cycle `fwd_ex_o`=0 and `fwd_mem_o`=2'b01.
- MUL with `MUL_CYCLES`=3 -> `stall_o`=1 for 2 cycles, MEM receives 2 bubbles, then advance. Repeat with `MUL_CYCLES`=1 -> no stall.
- BGE in EX with `br_taken_i`=1 and a hazarding LW-use in ID -> `flush_o`=1, `stall_o`=0, EX becomes a bubble next cycle. The same with `br_taken_i`=0 -> no flush.
- SW in MEM with `mem_ready_i`=0 for 3 cycles while MUL is in MULW -> `stall_o`=1 throughout, `cnt` frozen, total stall = 2+3 cycles.
- `rst_i` asserted while in MULW with `cnt`=1 -> next cycle state RUN, `ex_valid_o`=0, `mem_valid_o`=0, all outputs 0.
